// File: rtl/lzc_pkg.sv
// ============================================================================
// Module  : lzc_pkg
// Brief   : Shared types and helpers for the sequential leading-zero counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lzc_pkg;

    typedef enum logic {
        LZC_ZEROS = 1'b0,
        LZC_ONES  = 1'b1
    } lzc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lzc_state_e;

    // Count width must hold the value WIDTH itself, hence the extra bit.
    function automatic int lzc_count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_chunk.sv
// ============================================================================
// Module  : lzc_chunk
// Brief   : Combinational CHUNK-bit leading-zero count, radix-2 recursive tree.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lzc_chunk #(
    parameter  int CHUNK = 16,
    localparam int CW    = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] data,
    output logic [CW-1:0]    count,
    output logic             nonzero
);

    generate
        if (CHUNK == 2) begin : g_base
            assign nonzero = |data;
            assign count   = ~data[1];
        end else begin : g_tree
            logic [CW-2:0] cnt_hi;
            logic [CW-2:0] cnt_lo;
            logic          nz_hi;
            logic          nz_lo;

            lzc_chunk #(.CHUNK(CHUNK/2)) u_hi (
                .data    (data[CHUNK-1 -: CHUNK/2]),
                .count   (cnt_hi),
                .nonzero (nz_hi)
            );

            lzc_chunk #(.CHUNK(CHUNK/2)) u_lo (
                .data    (data[CHUNK/2-1:0]),
                .count   (cnt_lo),
                .nonzero (nz_lo)
            );

            // Count is only meaningful when nonzero is set.
            assign nonzero = nz_hi | nz_lo;
            assign count   = nz_hi ? {1'b0, cnt_hi} : {1'b1, cnt_lo};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/lzc_seq.sv
// ============================================================================
// Module  : lzc_seq
// Brief   : Handshaked multi-cycle leading-zero/one counter, CHUNK bits/cycle.
//           Optional macro LZC_SEQ_FIXED_LATENCY_EN: always scan all chunks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lzc_seq
    import lzc_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int CHUNK  = 16,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int COUNT  = lzc_count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COUNT-1:0] Z,
    output logic             all_zero
);

    localparam int              IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int              CW       = $clog2(CHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK < 2 || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_chunk
            $error("lzc_seq: CHUNK must be a power of two and at least 2");
        end
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("lzc_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    lzc_state_e       state;
    logic [WIDTH-1:0] operand;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    chunk_cnt;
    logic             chunk_nz;
    logic [COUNT-1:0] chunk_z;
    logic             accept;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
    logic             hit_found;
    logic [COUNT-1:0] hit_z;
`endif

    assign chunk = operand[WIDTH-1-int'(idx)*CHUNK -: CHUNK];

    lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
        .data    (chunk),
        .count   (chunk_cnt),
        .nonzero (chunk_nz)
    );

    // CHUNK is a power of two, so idx*CHUNK + count is a plain concatenation.
    assign chunk_z  = COUNT'({idx, chunk_cnt});
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            operand   <= '0;
            idx       <= '0;
            Z         <= '0;
            all_zero  <= 1'b0;
            out_valid <= 1'b0;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
            hit_found <= 1'b0;
            hit_z     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Leading ones are counted as leading zeros of ~A.
                        operand   <= (lzc_mode_e'(mode) == LZC_ONES) ? ~A : A;
                        idx       <= '0;
                        state     <= SCAN;
                        out_valid <= 1'b0;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
                        hit_found <= 1'b0;
`endif
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                SCAN: begin
`ifdef LZC_SEQ_FIXED_LATENCY_EN
                    if (chunk_nz && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_z     <= chunk_z;
                    end
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (hit_found) begin
                            Z        <= hit_z;
                            all_zero <= 1'b0;
                        end else if (chunk_nz) begin
                            Z        <= chunk_z;
                            all_zero <= 1'b0;
                        end else begin
                            Z        <= COUNT'(WIDTH);
                            all_zero <= 1'b1;
                        end
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
`else
                    if (chunk_nz) begin
                        Z         <= chunk_z;
                        all_zero  <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (idx == LAST_IDX) begin
                        Z         <= COUNT'(WIDTH);
                        all_zero  <= 1'b1;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lzc_seq.sv
// ============================================================================
// Module  : tb_lzc_seq
// Brief   : Self-checking bench for lzc_seq: directed cases plus random traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lzc_seq;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int COUNT  = 7;
    localparam int NRAND  = 300;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic             mode      = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [COUNT-1:0] z;
    logic             all_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lzc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (z),
        .all_zero  (all_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Walk from the MSB until a bit differs from the counted polarity.
    function automatic int ref_count(input logic [63:0] v, input logic m);
        int n = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i] != m) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_latency(input int n);
`ifdef LZC_SEQ_FIXED_LATENCY_EN
        return NCHUNK;
`else
        return (n >= WIDTH) ? NCHUNK : n / CHUNK + 1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic accept_op(input logic [63:0] v, input logic m);
        a        = v;
        mode     = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        mode     = ~m;
    endtask

    task automatic run_op(input string tag, input logic [63:0] v, input logic m);
        int lat;
        int n;
        n = ref_count(v, m);
        check({tag, " in_ready"}, in_ready, 1);
        accept_op(v, m);
        wait_result(lat);
        check({tag, " latency"}, lat, ref_latency(n));
        check({tag, " Z"}, z, n);
        check({tag, " all_zero"}, all_zero, n == WIDTH);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int sent;
        int recv;
        int cyc;
        int e;
        int exp_q[$];
        logic fire_in;
        logic fire_out;
        logic [63:0] base;

        #12;
        check("reset out_valid", out_valid, 0);
        check("reset Z", z, 0);
        check("reset all_zero", all_zero, 0);
        rst_n = 1'b1;
        step();
        check("post-reset in_ready", in_ready, 1);

        run_op("t1", 64'h8000_0000_0000_0000, 1'b0);
        run_op("t2", 64'h0000_0000_0001_0000, 1'b0);
        run_op("t3 zero", 64'h0, 1'b0);
        run_op("t3 ones", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);

        // Hold the result, then overlap the next accept with the consume.
        accept_op(64'h0000_0F00_0000_0000, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check("t4 hold out_valid", out_valid, 1);
            check("t4 hold Z", z, 20);
            check("t4 hold all_zero", all_zero, 0);
            check("t4 hold in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 64'h1;
        mode      = 1'b0;
        #1;
        check("t4 in_ready with out_ready", in_ready, 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4 consumed", out_valid, 0);
        wait_result(lat);
        check("t4 b2b latency", lat, ref_latency(63));
        check("t4 b2b Z", z, 63);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a scan.
        accept_op(64'h1, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 reset out_valid", out_valid, 0);
        check("t5 reset Z", z, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("t5 in_ready", in_ready, 1);
        run_op("t5 fresh", 64'h0000_8000_0000_0000, 1'b0);

        // Random traffic with random valid/ready; results must arrive in order.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < NRAND || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            fire_out = out_valid && out_ready;
            fire_in  = in_valid && in_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("rnd unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd Z", z, e);
                    check("rnd all_zero", all_zero, e == WIDTH);
                    recv++;
                end
            end
            if (fire_in) begin
                exp_q.push_back(ref_count(a, mode));
                sent++;
            end
            step();
            cyc++;
            if (fire_in) in_valid = 1'b0;
            if (!in_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
                base     = {$urandom, $urandom} >> $urandom_range(0, 64);
                mode     = 1'($urandom_range(0, 1));
                a        = mode ? ~base : base;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rnd results delivered", recv, NRAND);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lzc_seq.md
Name: lzc_seq

Overview:
Multi-cycle, handshaked leading-zero/leading-one counter for wide operands. It scans the operand MSB-first, CHUNK bits per cycle, using one combinational chunk counter that is reused every cycle. This trades latency for area on widths where a single-cycle tree counter misses timing. It sits between valid/ready producers (normaliser, FP datapath) and consumers of the shift amount.

Parameters:
WIDTH, 64, operand width; must be a multiple of CHUNK.
CHUNK, 16, bits examined per cycle; power of two, >= 2.
NCHUNK, WIDTH/CHUNK, derived: number of scan steps.
COUNT, $clog2(WIDTH)+1, derived: count width, wide enough to represent WIDTH itself.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand valid.
in_ready  out  1  block can accept an operand.
A  in  WIDTH  operand.
mode  in  1  0 = count leading zeros, 1 = count leading ones; sampled with A.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
Z  out  COUNT  leading-zero/one count, 0..WIDTH.
all_zero  out  1  1 when no terminating bit was found (Z == WIDTH).

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; out_valid=0, Z=0, all_zero=0, chunk index=0. in_ready=1 once out of reset.
- States:
  - IDLE: in_ready=1. On in_valid, latch A, or ~A when mode=1. Set idx=0, go to SCAN.
  - SCAN: in_ready=0. The chunk counter examines operand bits [WIDTH-1-idx*CHUNK -: CHUNK].
    - Chunk nonzero: Z = idx*CHUNK + chunk_count, all_zero=0, go to DONE.
    - Chunk zero and idx==NCHUNK-1: Z=WIDTH, all_zero=1, go to DONE.
    - Otherwise: idx++.
  - DONE: out_valid=1. Z and all_zero are held stable until out_ready.
    - out_ready & in_valid: accept the new operand in the same cycle, go straight to SCAN (back-to-back).
    - out_ready & !in_valid: go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready only.
- Latency from accept edge to out_valid: k+1 cycles, where k = index of the first nonzero chunk. All-zero operand takes NCHUNK cycles (early-exit build).
- Outputs are registered. Z and all_zero change only on the SCAN->DONE transition.
- A and mode are ignored outside the accept cycle. Operand changes during SCAN have no effect.
- Reset asserted mid-SCAN or in DONE: the result is discarded and out_valid drops immediately (asynchronous).
- Elaboration errors: WIDTH%CHUNK != 0, CHUNK not a power of two, CHUNK<2.

Optional Feature:
LZC_SEQ_FIXED_LATENCY_EN:
- Defined: SCAN always runs all NCHUNK cycles. The first nonzero chunk's result is captured into a "hit" register, and later chunks do not overwrite it. Latency is constant NCHUNK cycles, which suits lockstep pipelines.
- Undefined: early exit as described in Behaviour; latency is data-dependent.

Decomposition:
- Package lzc_pkg:
  - lzc_mode_e (LZC_ZEROS=0, LZC_ONES=1).
  - lzc_state_e (IDLE, SCAN, DONE).
  - Function clog2-based COUNT helper.
- Sub-module lzc_chunk #(CHUNK): combinational CHUNK-bit leading-zero count plus nonzero flag, built as a radix-2 tree of base elements. It is instantiated once in lzc_seq.

Test Plan:
(WIDTH=64, CHUNK=16, early-exit build unless noted)
1. A=64'h8000_0000_0000_0000, mode=0 -> Z=0, all_zero=0, out_valid 1 cycle after accept.
2. A=64'h0000_0000_0001_0000, mode=0 -> Z=47, all_zero=0, out_valid 3 cycles after accept. With LZC_SEQ_FIXED_LATENCY_EN: same Z, 4 cycles.
3. A=0, mode=0 -> Z=64, all_zero=1, 4 cycles. Then A=64'hFFFF_FFFF_FFFF_FFF0, mode=1 -> Z=60, all_zero=0.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid, Z and all_zero stable, in_ready=0. Raise out_ready with in_valid=1, A=1 -> both handshakes in the same cycle, next result Z=63 with no IDLE bubble.
5. Drop rst_n during SCAN of A=1 -> out_valid=0 and Z=0 immediately. After release, in_ready=1 and a fresh A=64'h0000_8000_0000_0000 gives Z=16.
6. Random A/mode with random valid/ready -> Z matches a reference count. Each result is delivered exactly once and in order.
